// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI master transfer path.
//   spi_state_t      : transfer controller states (IDLE/SETUP/SHIFT/HOLD)
//   CPOL, CPHA       : fixed SPI mode 0 (clock idles low, sample on rising edge)
//   bit_cnt_width()  : width of the SCLK toggle counter for a given word size
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // The counter must reach 2*data_w (two toggles per bit) without wrapping,
  // so it gets one bit more than log2 of that count.
  function automatic int bit_cnt_width(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
// Bit-rate tick generator. Counts 0..D-1 while enabled and pulses tick
// on the last count, then wraps. Cleared to 0 whenever disabled.
// Ports:
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   en   : count enable
//   div  : half-period D in clk cycles; 0 behaves as 1
//   tick : combinational pulse in the cycle the count equals D-1
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;

  // A zero divider would underflow D-1, so it is clamped to D=1 (tick every cycle).
  always_comb begin
    last_cnt = '0;
    if (div != '0) begin
      last_cnt = div - DIV_W'(1);
    end
  end

  assign tick = en && (cnt == last_cnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl
// SPI master transfer controller: one mode-0, MSB-first word per request.
// Ports:
//   clk, rstn    : system clock, asynchronous active-low reset
//   SPI_BITRATE  : SCLK half-period in clk cycles, latched on accept
//   start_valid  : transfer request carrying tx_data
//   start_ready  : controller idle and able to accept
//   tx_data      : word to send, latched on accept
//   rx_data      : received word, updated with rx_valid and held
//   rx_valid     : one-cycle pulse at end of transfer
//   busy         : high from the cycle after accept through the rx_valid cycle
//   cs_n, sclk, mosi : SPI pin drivers (registered)
//   miso         : SPI serial input, already in the sclk domain
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DIV_W-1:0]  SPI_BITRATE,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_TOGGLE = CNT_W'(2 * DATA_W - 1);

  spi_state_t        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  bit_cnt;

  logic              accept;
  logic              tick;
  logic              clk_en;
  logic [DIV_W-1:0]  clk_div;
  logic              sample_edge;

  assign accept = start_valid && start_ready;

  // The tick generator already runs in the accept cycle, using the incoming
  // bit-rate directly, so the SETUP wait spans the accept cycle plus D-1 more.
  // This keeps every phase exactly D cycles long including the D=1 case.
  assign clk_en  = accept || (state != IDLE);
  assign clk_div = (state == IDLE) ? SPI_BITRATE : div_q;

  // Leading edge of the SCLK period is where mode-0 samples miso.
  assign sample_edge = (sclk == CPOL) ^ CPHA;

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clk  (clk),
    .rstn (rstn),
    .en   (clk_en),
    .div  (clk_div),
    .tick (tick)
  );

  // Transfer sequencer: owns the state, both shift registers and every pin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      div_q       <= '0;
      bit_cnt     <= '0;
      cs_n        <= 1'b1;
      sclk        <= CPOL;
      mosi        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // start_ready is low in the rx_valid cycle, so a request there is
          // held off until the following cycle.
          if (rx_valid) begin
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end else if (accept) begin
            tx_sr       <= tx_data;
            rx_sr       <= '0;
            div_q       <= SPI_BITRATE;
            bit_cnt     <= '0;
            cs_n        <= 1'b0;
            mosi        <= tx_data[DATA_W-1];
            busy        <= 1'b1;
            start_ready <= 1'b0;
            // With D=1 the setup tick lands in the accept cycle itself.
            state       <= tick ? SHIFT : SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            sclk    <= ~sclk;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (sample_edge) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end else begin
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[DATA_W-2];
            end
            if (bit_cnt == LAST_TOGGLE) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl
// Directed bench for spi_xfer_ctrl. Inputs change 1ns after the rising
// edge; everything is observed on the falling edge. Cycle 0 is the cycle
// in which start_valid && start_ready is seen.
module tb_spi_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] SPI_BITRATE = 32'd0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [7:0]  tx_data = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        loopback = 1'b1;
  logic        miso_fix = 1'b0;
  wire         miso_w = loopback ? mosi : miso_fix;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .DATA_W(8),
    .DIV_W (32)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .SPI_BITRATE (SPI_BITRATE),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .mosi        (mosi),
    .miso        (miso_w)
  );

  // Monitor: timestamps accepts, sclk rises, cs_n falls and rx_valid pulses.
  int         cyc = 0;
  int         acc_cyc = 0;
  int         acc_total = 0;
  int         acc_hist[16];
  int         rise_n = 0;
  int         rise_cyc[32];
  logic [7:0] mosi_word = 8'h00;
  int         cs_fall_cyc = 0;
  int         rxv_cyc = 0;
  logic [7:0] rxv_data = 8'h00;
  int         rxv_total = 0;
  logic       sclk_d = 1'b0;
  logic       cs_d = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rstn && start_valid && start_ready) begin
      acc_cyc = cyc;
      if (acc_total < 16) acc_hist[acc_total] = cyc;
      acc_total = acc_total + 1;
      rise_n = 0;
      mosi_word = 8'h00;
    end
    if (sclk && !sclk_d) begin
      if (rise_n < 32) rise_cyc[rise_n] = cyc;
      rise_n = rise_n + 1;
      mosi_word = {mosi_word[6:0], mosi};
    end
    if (!cs_n && cs_d) cs_fall_cyc = cyc;
    if (rx_valid) begin
      rxv_cyc = cyc;
      rxv_data = rx_data;
      rxv_total = rxv_total + 1;
    end
    sclk_d = sclk;
    cs_d = cs_n;
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Raise a request and hold it until the controller takes it.
  task automatic applyStimulus(input logic [31:0] rate, input logic [7:0] data);
    int n;
    n = 0;
    @(posedge clk); #1;
    SPI_BITRATE = rate;
    tx_data = data;
    start_valid = 1'b1;
    @(negedge clk);
    while (!start_ready && n < 1000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("accept_seen", longint'(start_ready), 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (rxv_total < target && n < budget) begin
      @(negedge clk); #1;
      n = n + 1;
    end
    checkOutput({tag, "_done"}, longint'(rxv_total >= target), 1);
  endtask

  // Timing and data checks for one completed transfer with half-period d.
  task automatic xferCheck(input string tag, input int d, input logic [7:0] exp_rx,
                           input logic [7:0] exp_mosi);
    int bad;
    bad = 0;
    checkOutput({tag, "_rise_count"}, rise_n, 8);
    checkOutput({tag, "_first_rise"}, rise_cyc[0] - acc_cyc, 2 * d);
    for (int i = 1; i < 8; i++) begin
      if (rise_cyc[i] - rise_cyc[i-1] != 2 * d) bad = bad + 1;
    end
    checkOutput({tag, "_rise_spacing_bad"}, bad, 0);
    checkOutput({tag, "_mosi_bits"}, mosi_word, exp_mosi);
    checkOutput({tag, "_cs_fall"}, cs_fall_cyc - acc_cyc, 1);
    checkOutput({tag, "_rx_latency"}, rxv_cyc - acc_cyc, 18 * d);
    checkOutput({tag, "_rx_data"}, rxv_data, exp_rx);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int r0;
    int a0;
    int n;

    // Reset state
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_cs_n", cs_n, 1);
    checkOutput("rst_sclk", sclk, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_start_ready", start_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk); #1;
      if (cs_n !== 1'b1 || sclk !== 1'b0 || rx_valid !== 1'b0 || busy !== 1'b0 ||
          start_ready !== 1'b1) bad = bad + 1;
    end
    checkOutput("idle_quiet_bad", bad, 0);

    // Basic loopback transfer, D=10
    loopback = 1'b1;
    r0 = rxv_total;
    applyStimulus(32'd10, 8'hA5);
    waitDone("basic", r0 + 1, 1000);
    checkOutput("basic_cs_n_at_rxv", cs_n, 1);
    checkOutput("basic_ready_at_rxv", start_ready, 0);
    checkOutput("basic_busy_at_rxv", busy, 1);
    xferCheck("basic", 10, 8'hA5, 8'hA5);
    @(negedge clk); #1;
    checkOutput("basic_ready_after", start_ready, 1);
    checkOutput("basic_busy_after", busy, 0);
    checkOutput("basic_rxv_after", rx_valid, 0);
    checkOutput("basic_rx_hold", rx_data, 8'hA5);

    // Zero bit-rate clamps to D=1, miso tied high
    loopback = 1'b0;
    miso_fix = 1'b1;
    r0 = rxv_total;
    applyStimulus(32'd0, 8'h3C);
    waitDone("d0", r0 + 1, 200);
    xferCheck("d0", 1, 8'hFF, 8'h3C);

    // Bit-rate change mid-transfer is ignored until the next accept
    loopback = 1'b1;
    r0 = rxv_total;
    applyStimulus(32'd10, 8'h5A);
    repeat (50) @(negedge clk);
    SPI_BITRATE = 32'd3;
    waitDone("chg", r0 + 1, 1000);
    xferCheck("chg", 10, 8'h5A, 8'h5A);
    r0 = rxv_total;
    applyStimulus(32'd3, 8'h81);
    waitDone("d3", r0 + 1, 500);
    xferCheck("d3", 3, 8'h81, 8'h81);

    // start_valid held high for 400 cycles: accepts at 0, 181, 362
    a0 = acc_total;
    r0 = rxv_total;
    @(posedge clk); #1;
    SPI_BITRATE = 32'd10;
    tx_data = 8'hC3;
    start_valid = 1'b1;
    repeat (400) @(negedge clk);
    @(posedge clk); #1;
    start_valid = 1'b0;
    checkOutput("b2b_accepts", acc_total - a0, 3);
    checkOutput("b2b_gap1", acc_hist[a0+1] - acc_hist[a0], 181);
    checkOutput("b2b_gap2", acc_hist[a0+2] - acc_hist[a0+1], 181);
    waitDone("b2b", r0 + 3, 400);
    checkOutput("b2b_rx_data", rxv_data, 8'hC3);

    // Reset at the 4th sclk rise
    r0 = rxv_total;
    applyStimulus(32'd10, 8'h96);
    n = 0;
    while (rise_n < 4 && n < 500) begin
      @(negedge clk); #1;
      n = n + 1;
    end
    checkOutput("midrst_rise_reached", rise_n, 4);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_cs_n", cs_n, 1);
    checkOutput("midrst_sclk", sclk, 0);
    checkOutput("midrst_mosi", mosi, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", start_ready, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (250) @(negedge clk);
    #1;
    checkOutput("midrst_no_rxv", rxv_total - r0, 0);
    checkOutput("midrst_rx_data", rx_data, 0);
    r0 = rxv_total;
    applyStimulus(32'd2, 8'h69);
    waitDone("post_rst", r0 + 1, 300);
    xferCheck("post_rst", 2, 8'h69, 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
